mic_frame_ctrl: RTL and testbench
=================================

MIC_FRAME_CTRL -- requirements
Module: mic_frame_ctrl

Interface
REQ-001 Parameter DECIM, default 2, keep 1 of every DECIM filtered samples (1..16).
REQ-002 Parameter FRAME_LEN, default 256, samples per frame (power of two, 16..1024); AW = log2(FRAME_LEN).
REQ-003 Parameter WARMUP, default 23, filtered samples discarded after enable (filter tap count).
REQ-004 clk  in  1  sole clock; all logic rising-edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 enable  in  1  run request; level.
REQ-007 mic_data  in  24  signed raw microphone sample; mic_rdy  in  1  one-cycle valid strobe.
REQ-008 flt_data_in  out  24  sample to filter; flt_in_rdy  out  1  strobe to filter.
REQ-009 flt_data_out  in  24  filtered sample; flt_out_rdy  in  1  strobe from filter (fixed filter latency, no backpressure).
REQ-010 buf_wr  out  1; buf_bank  out  1; buf_addr  out  AW; buf_wdata  out  24  frame-buffer write port.
REQ-011 frame_rdy  out  1  level, completed frame waiting; frame_bank  out  1  bank holding it; frame_ack  in  1  one-cycle consumer acknowledge.
REQ-012 overflow  out  1  sticky, frame dropped.

Function
REQ-013 FSM states IDLE, WARMUP, RUN; reset state IDLE.
REQ-014 IDLE -> WARMUP on enable=1; WARMUP -> RUN after WARMUP counted flt_out_rdy strobes; any state -> IDLE on enable=0 in the same cycle.
REQ-015 In WARMUP/RUN, mic_data/mic_rdy registered once onto flt_data_in/flt_in_rdy (1-cycle latency); in IDLE flt_in_rdy=0, flt_data_in holds.
REQ-016 In WARMUP, filter outputs discarded; no buf_wr.
REQ-017 In RUN, a decimation counter 0..DECIM-1 advances per flt_out_rdy; only the strobe at count 0 writes.
REQ-018 Write: buf_wr=1 one cycle after the accepted strobe, buf_wdata=flt_data_out, buf_addr=write index, buf_bank=active bank; index then increments.
REQ-019 Write at index FRAME_LEN-1 completes a frame: index wraps to 0, active bank toggles, frame_bank <= completed bank, frame_rdy <= 1 next cycle.
REQ-020 frame_ack while frame_rdy=1 clears frame_rdy next cycle; frame_ack while frame_rdy=0 ignored.
REQ-021 Frame completes while frame_rdy=1 and no frame_ack that cycle: frame dropped, overflow <= 1, active bank not toggled, frame_bank/frame_rdy unchanged, index wraps to 0.
REQ-022 Frame completion and frame_ack in the same cycle: ack applied first; new frame accepted, frame_rdy stays 1, frame_bank updates, no overflow.
REQ-023 Transition to IDLE: partial frame discarded, index and decimation counter cleared, filter outputs still in flight ignored; frame_rdy, frame_bank, overflow, active bank retained.
REQ-024 overflow clears only on reset.
REQ-025 All outputs registered; no combinational input-to-output path.

Reset
REQ-026 On rst=0: state IDLE; flt_data_in=0, flt_in_rdy=0, buf_wr=0, buf_bank=0, buf_addr=0, buf_wdata=0, frame_rdy=0, frame_bank=0, overflow=0; active bank 0; all counters 0.
REQ-027 Reset mid-frame abandons all frame state; no write is issued in the cycle reset deasserts.

Configuration
REQ-028 Macro MIC_FRAME_CTRL_OVF_CNT_EN defined: extra output ovf_count (16 bits) increments per dropped frame, saturates at 16'hFFFF, reset 0.
REQ-029 Macro undefined: ovf_count port absent; all other behaviour identical.

Structure
REQ-030 Shared package mic_pkg: state enum (IDLE/WARMUP/RUN), SAMPLE_W=24, default DECIM/FRAME_LEN/WARMUP constants.
REQ-031 One sub-module: mic_frame_decim (decimation counter plus write-index/bank generation); FSM and handshake stay in top.

Verification
REQ-032 enable=1, WARMUP=23, DECIM=2, FRAME_LEN=16, ramp 1,2,3... -> first buf_wr after 23 discarded outputs, 16 writes on every 2nd output, buf_bank=0, frame_rdy=1 with frame_bank=0.
REQ-033 Ack each frame within 10 cycles, run 4 frames -> banks alternate 0,1,0,1; overflow stays 0.
REQ-034 Never ack, run 2 frames -> frame_rdy=1, frame_bank=0, overflow=1 at end of second frame, ovf_count=1 when macro defined.
REQ-035 frame_ack same cycle as completion of second frame -> frame_rdy stays 1, frame_bank=1, overflow=0.
REQ-036 enable dropped at index 7, re-raised -> WARMUP repeats, next write at buf_addr=0, prior frame_rdy preserved.
REQ-037 rst asserted mid-frame -> all outputs at reset values immediately, no buf_wr on release.

Source files
------------

// File: rtl/mic_pkg.sv
// Shared types and default constants for the microphone frame controller.
package mic_pkg;

  localparam int SAMPLE_W      = 24;
  localparam int DEF_DECIM     = 2;
  localparam int DEF_FRAME_LEN = 256;
  localparam int DEF_WARMUP    = 23;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2
  } state_t;

endpackage

// File: rtl/mic_frame_decim.sv
// Decimation counter plus ping-pong frame write index and bank tracking.
module mic_frame_decim
  import mic_pkg::*;
#(
  parameter int  DECIM     = DEF_DECIM,
  parameter int  FRAME_LEN = DEF_FRAME_LEN,
  localparam int AW        = $clog2(FRAME_LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          strobe,
  input  logic          frame_busy,
  output logic          wr_en,
  output logic [AW-1:0] wr_idx,
  output logic          wr_bank,
  output logic          frame_done,
  output logic          frame_drop
);

  localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic [DW-1:0] dec_cnt;
  logic [AW-1:0] idx;
  logic          bank;

  assign wr_en      = strobe && (dec_cnt == '0);
  assign frame_done = wr_en && (idx == AW'(FRAME_LEN - 1));
  assign frame_drop = frame_done && frame_busy;
  assign wr_idx     = idx;
  assign wr_bank    = bank;

  // A dropped frame keeps writing into the same bank; only accepted frames swap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dec_cnt <= '0;
      idx     <= '0;
      bank    <= 1'b0;
    end else if (clear) begin
      dec_cnt <= '0;
      idx     <= '0;
    end else if (strobe) begin
      dec_cnt <= (dec_cnt == DW'(DECIM - 1)) ? '0 : dec_cnt + DW'(1);
      if (wr_en) begin
        idx <= idx + AW'(1);
        if (frame_done && !frame_busy) bank <= ~bank;
      end
    end
  end

endmodule

// File: rtl/mic_frame_ctrl.sv
// Microphone capture controller: filter feed, warm-up discard, decimated ping-pong frame writes.
// Optional saturating drop counter output ovf_count when MIC_FRAME_CTRL_OVF_CNT_EN is defined.
module mic_frame_ctrl #(
  parameter int  DECIM     = mic_pkg::DEF_DECIM,
  parameter int  FRAME_LEN = mic_pkg::DEF_FRAME_LEN,
  parameter int  WARMUP    = mic_pkg::DEF_WARMUP,
  localparam int AW        = $clog2(FRAME_LEN),
  localparam int SW        = mic_pkg::SAMPLE_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic [SW-1:0] mic_data,
  input  logic          mic_rdy,
  output logic [SW-1:0] flt_data_in,
  output logic          flt_in_rdy,
  input  logic [SW-1:0] flt_data_out,
  input  logic          flt_out_rdy,
  output logic          buf_wr,
  output logic          buf_bank,
  output logic [AW-1:0] buf_addr,
  output logic [SW-1:0] buf_wdata,
  output logic          frame_rdy,
  output logic          frame_bank,
  input  logic          frame_ack,
  output logic          overflow
`ifdef MIC_FRAME_CTRL_OVF_CNT_EN
  ,
  output logic [15:0]   ovf_count
`endif
);

  localparam int WCW = $clog2(WARMUP + 1);

  mic_pkg::state_t state, state_next;
  logic [WCW-1:0]  warm_cnt;
  logic            active;
  logic            run_strobe;
  logic            wr_en, wr_bank, frame_done, frame_drop;
  logic [AW-1:0]   wr_idx;

  always_comb begin
    state_next = state;
    case (state)
      mic_pkg::IDLE:   if (enable) state_next = mic_pkg::WARMUP;
      mic_pkg::WARMUP: if (flt_out_rdy && warm_cnt == WCW'(WARMUP - 1)) state_next = mic_pkg::RUN;
      mic_pkg::RUN:    state_next = mic_pkg::RUN;
      default:         state_next = mic_pkg::IDLE;
    endcase
    if (!enable) state_next = mic_pkg::IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= mic_pkg::IDLE;
    else      state <= state_next;
  end

  // Dropping enable takes effect in the same cycle, so gate everything on it too.
  assign active     = enable && (state != mic_pkg::IDLE);
  assign run_strobe = enable && (state == mic_pkg::RUN) && flt_out_rdy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                                  warm_cnt <= '0;
    else if (state != mic_pkg::WARMUP || !enable)              warm_cnt <= '0;
    else if (flt_out_rdy)                                      warm_cnt <= warm_cnt + WCW'(1);
  end

  mic_frame_decim #(
    .DECIM     (DECIM),
    .FRAME_LEN (FRAME_LEN)
  ) u_decim (
    .clk        (clk),
    .rst        (rst),
    .clear      (!enable),
    .strobe     (run_strobe),
    .frame_busy (frame_rdy && !frame_ack),
    .wr_en      (wr_en),
    .wr_idx     (wr_idx),
    .wr_bank    (wr_bank),
    .frame_done (frame_done),
    .frame_drop (frame_drop)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flt_data_in <= '0;
      flt_in_rdy  <= 1'b0;
      buf_wr      <= 1'b0;
      buf_bank    <= 1'b0;
      buf_addr    <= '0;
      buf_wdata   <= '0;
      frame_rdy   <= 1'b0;
      frame_bank  <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      flt_in_rdy <= active && mic_rdy;
      if (active && mic_rdy) flt_data_in <= mic_data;
      buf_wr <= wr_en;
      if (wr_en) begin
        buf_addr  <= wr_idx;
        buf_bank  <= wr_bank;
        buf_wdata <= flt_data_out;
      end
      // An ack coinciding with completion frees the slot before the new frame claims it.
      if (frame_done && !frame_drop) begin
        frame_rdy  <= 1'b1;
        frame_bank <= wr_bank;
      end else if (frame_ack) begin
        frame_rdy <= 1'b0;
      end
      if (frame_drop) overflow <= 1'b1;
    end
  end

`ifdef MIC_FRAME_CTRL_OVF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                   ovf_count <= '0;
    else if (frame_drop && ovf_count != 16'hFFFF) ovf_count <= ovf_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_mic_frame_ctrl.sv
// Directed bench for mic_frame_ctrl: a reference model pushes expected writes, a monitor pops and compares.
module tb_mic_frame_ctrl;

  localparam int DECIM     = 2;
  localparam int FRAME_LEN = 16;
  localparam int WARMUP    = 23;
  localparam int AW        = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enable = 1'b0;
  logic [23:0]   mic_data = '0;
  logic          mic_rdy = 1'b0;
  logic [23:0]   flt_data_in;
  logic          flt_in_rdy;
  logic [23:0]   flt_data_out = '0;
  logic          flt_out_rdy = 1'b0;
  logic          buf_wr, buf_bank, frame_rdy, frame_bank, overflow;
  logic [AW-1:0] buf_addr;
  logic [23:0]   buf_wdata;
  logic          frame_ack = 1'b0;
`ifdef MIC_FRAME_CTRL_OVF_CNT_EN
  logic [15:0]   ovf_count;
`endif

  always #5 clk = ~clk;

  mic_frame_ctrl #(.DECIM(DECIM), .FRAME_LEN(FRAME_LEN), .WARMUP(WARMUP)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .mic_data     (mic_data),
    .mic_rdy      (mic_rdy),
    .flt_data_in  (flt_data_in),
    .flt_in_rdy   (flt_in_rdy),
    .flt_data_out (flt_data_out),
    .flt_out_rdy  (flt_out_rdy),
    .buf_wr       (buf_wr),
    .buf_bank     (buf_bank),
    .buf_addr     (buf_addr),
    .buf_wdata    (buf_wdata),
    .frame_rdy    (frame_rdy),
    .frame_bank   (frame_bank),
    .frame_ack    (frame_ack),
    .overflow     (overflow)
`ifdef MIC_FRAME_CTRL_OVF_CNT_EN
    ,
    .ovf_count    (ovf_count)
`endif
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          bank;
    logic [23:0]   data;
  } wr_t;

  wr_t  sb[$];
  wr_t  mon_e;
  int   checks = 0;
  int   errors = 0;

  // Reference model state (0 idle, 1 warm-up, 2 run)
  int          m_state = 0;
  int          m_warm = 0;
  int          m_dec = 0;
  int          m_idx = 0;
  logic        m_bank = 1'b0;
  logic        m_frame_rdy = 1'b0;
  logic        m_frame_bank = 1'b0;
  logic        m_ovf = 1'b0;
  int          m_ovf_cnt = 0;
  logic [23:0] ramp = 24'd1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (buf_wr === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_write", {31'd0, buf_wr}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("wr_addr", {28'd0, buf_addr}, {28'd0, mon_e.addr});
        check("wr_bank", {31'd0, buf_bank}, {31'd0, mon_e.bank});
        check("wr_data", {8'd0, buf_wdata}, {8'd0, mon_e.data});
        $display("write addr=%0d bank=%0d data=%0d", buf_addr, buf_bank, buf_wdata);
      end
    end else if (rst === 1'b1 && buf_wr !== 1'b0) begin
      check("buf_wr_known", {31'd0, buf_wr}, 32'd0);
    end
  end

  task automatic strobe(input logic ack);
    logic busy;
    @(negedge clk);
    flt_out_rdy  = 1'b1;
    flt_data_out = ramp;
    frame_ack    = ack;
    busy = m_frame_rdy && !ack;
    if (ack) m_frame_rdy = 1'b0;
    if (m_state == 1) begin
      if (m_warm == WARMUP - 1) begin
        m_state = 2;
        m_warm  = 0;
      end else begin
        m_warm++;
      end
    end else if (m_state == 2) begin
      if (m_dec == 0) begin
        sb.push_back(wr_t'{AW'(m_idx), m_bank, ramp});
        if (m_idx == FRAME_LEN - 1) begin
          m_idx = 0;
          if (busy) begin
            m_ovf = 1'b1;
            m_ovf_cnt++;
          end else begin
            m_frame_rdy  = 1'b1;
            m_frame_bank = m_bank;
            m_bank       = ~m_bank;
          end
        end else begin
          m_idx++;
        end
      end
      m_dec = (m_dec + 1) % DECIM;
    end
    ramp = ramp + 24'd1;
    @(negedge clk);
    flt_out_rdy = 1'b0;
    frame_ack   = 1'b0;
  endtask

  task automatic strobes(input int n);
    for (int i = 0; i < n; i++) strobe(1'b0);
  endtask

  task automatic ack_frame();
    @(negedge clk);
    frame_ack   = 1'b1;
    m_frame_rdy = 1'b0;
    @(negedge clk);
    frame_ack = 1'b0;
  endtask

  task automatic set_enable(input logic en);
    @(negedge clk);
    enable  = en;
    m_state = en ? 1 : 0;
    m_warm  = 0;
    m_dec   = 0;
    m_idx   = 0;
  endtask

  task automatic check_frame(input string tag);
    check({tag, "_frame_rdy"},  {31'd0, frame_rdy},  {31'd0, m_frame_rdy});
    check({tag, "_frame_bank"}, {31'd0, frame_bank}, {31'd0, m_frame_bank});
    check({tag, "_overflow"},   {31'd0, overflow},   {31'd0, m_ovf});
    $display("%s frame_rdy=%0d frame_bank=%0d overflow=%0d", tag, frame_rdy, frame_bank, overflow);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_flt_data_in"}, {8'd0, flt_data_in}, 32'd0);
    check({tag, "_flt_in_rdy"},  {31'd0, flt_in_rdy}, 32'd0);
    check({tag, "_buf_wr"},      {31'd0, buf_wr},     32'd0);
    check({tag, "_buf_bank"},    {31'd0, buf_bank},   32'd0);
    check({tag, "_buf_addr"},    {28'd0, buf_addr},   32'd0);
    check({tag, "_buf_wdata"},   {8'd0, buf_wdata},   32'd0);
    check({tag, "_frame_rdy"},   {31'd0, frame_rdy},  32'd0);
    check({tag, "_frame_bank"},  {31'd0, frame_bank}, 32'd0);
    check({tag, "_overflow"},    {31'd0, overflow},   32'd0);
`ifdef MIC_FRAME_CTRL_OVF_CNT_EN
    check({tag, "_ovf_count"},   {16'd0, ovf_count},  32'd0);
`endif
    $display("%s reset outputs checked", tag);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;

    // Idle: mic samples are not forwarded
    @(negedge clk);
    mic_rdy  = 1'b1;
    mic_data = 24'h0ABCDE;
    @(negedge clk);
    mic_rdy = 1'b0;
    check("idle_flt_in_rdy", {31'd0, flt_in_rdy}, 32'd0);
    check("idle_flt_data_in", {8'd0, flt_data_in}, 32'd0);

    // Forwarding with one-cycle latency once enabled
    set_enable(1'b1);
    @(negedge clk);
    mic_rdy  = 1'b1;
    mic_data = 24'h123456;
    @(negedge clk);
    mic_rdy = 1'b0;
    check("fwd_flt_in_rdy", {31'd0, flt_in_rdy}, 32'd1);
    check("fwd_flt_data_in", {8'd0, flt_data_in}, 32'h123456);
    @(negedge clk);
    check("fwd_flt_in_rdy_low", {31'd0, flt_in_rdy}, 32'd0);
    check("fwd_flt_data_hold", {8'd0, flt_data_in}, 32'h123456);

    // Warm-up then first frame into bank 0
    strobes(WARMUP);
    check("warmup_no_write_queued", sb.size(), 32'd0);
    strobes(FRAME_LEN * DECIM);
    check_frame("frame1");

    // Acked frames alternate banks
    for (int f = 0; f < 3; f++) begin
      ack_frame();
      strobes(FRAME_LEN * DECIM);
      check_frame("acked_frame");
    end
    ack_frame();
    check_frame("after_ack");

    // Completion coincident with ack
    strobes(FRAME_LEN * DECIM);
    check_frame("coinc_first");
    strobes(FRAME_LEN * DECIM - DECIM);
    strobe(1'b1);
    strobes(DECIM - 1);
    check_frame("coinc_second");
    ack_frame();

    // Never ack: second frame dropped
    strobes(FRAME_LEN * DECIM);
    check_frame("noack_first");
    strobes(FRAME_LEN * DECIM);
    check_frame("noack_second");
`ifdef MIC_FRAME_CTRL_OVF_CNT_EN
    check("ovf_count", {16'd0, ovf_count}, m_ovf_cnt);
`endif

    // Drop enable mid-frame at index 7, then restart
    strobes(7 * DECIM);
    set_enable(1'b0);
    strobe(1'b0);
    @(negedge clk);
    check_frame("disabled");
    set_enable(1'b1);
    strobes(WARMUP + 4 * DECIM);
    check_frame("restarted");
    repeat (2) @(negedge clk);
    check("sb_drain", sb.size(), 32'd0);

    // Asynchronous reset mid-frame
    strobes(3);
    #2 rst = 1'b0;
    #1 check_reset_outputs("async_reset");
    sb.delete();
    m_frame_rdy = 1'b0;
    m_frame_bank = 1'b0;
    m_ovf = 1'b0;
    m_bank = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    flt_out_rdy = 1'b1;
    @(negedge clk);
    flt_out_rdy = 1'b0;
    check("release_buf_wr", {31'd0, buf_wr}, 32'd0);
    repeat (3) @(negedge clk);
    check_frame("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
